// File: rtl/chain_slot_arbiter.sv
// Round-robin front end for a shared fixed-latency datapath: grants one requester
// per cycle, tracks issuer IDs alongside the chain, and drains on request.
module chain_slot_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int LAT     = 4
) (
  input  logic                      tau2015_clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      dp_in_valid,
  output logic [DATA_W-1:0]         dp_in_data,
  input  logic [DATA_W-1:0]         dp_out_data,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  input  logic                      drain_req,
  output logic                      halted
);

  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SCAN_W = ID_W + 1;
  localparam int CNT_W  = $clog2(LAT + 3);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   grant_id;
  logic [ID_W-1:0]   issue_id;
  logic [SCAN_W-1:0] scan_idx;
  logic              grant_found;
  logic              transfer;
  logic              rsp_fire;
  logic [LAT-1:0]    tag_valid;
  logic [ID_W-1:0]   tag_id [LAT];
  logic [CNT_W-1:0]  inflight;

  // Scan from rr_ptr upward with wraparound; first valid requester wins.
  always_comb begin
    req_ready   = '0;
    grant_id    = '0;
    grant_found = 1'b0;
    scan_idx    = '0;
    if (!rst && state == RUN && !drain_req) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        scan_idx = SCAN_W'(rr_ptr) + SCAN_W'(k);
        if (scan_idx >= SCAN_W'(NUM_REQ)) begin
          scan_idx = scan_idx - SCAN_W'(NUM_REQ);
        end
        if (!grant_found && req_valid[scan_idx[ID_W-1:0]]) begin
          grant_found = 1'b1;
          grant_id    = scan_idx[ID_W-1:0];
        end
      end
      if (grant_found) begin
        req_ready = NUM_REQ'(1) << grant_id;
      end
    end
  end

  assign transfer = |(req_valid & req_ready);
  assign rsp_fire = |rsp_valid;

  // Dropping drain_req always returns to RUN, even with work still in flight.
  always_comb begin
    state_nxt = state;
    halted    = 1'b0;
    unique case (state)
      RUN: begin
        if (drain_req) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (!drain_req) begin
          state_nxt = RUN;
        end else if (inflight == '0 && !transfer) begin
          state_nxt = HALTED;
        end
      end
      HALTED: begin
        halted = 1'b1;
        if (!drain_req) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge tau2015_clk) begin
    if (rst) begin
      state <= RUN;
      rr_ptr <= '0;
    end else begin
      state <= state_nxt;
      if (transfer) begin
        rr_ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
      end
    end
  end

  // Issue register feeds the chain; its ID enters the tag pipe one cycle later
  // so the last tag stage lines up with the cycle dp_out_data is valid.
  always_ff @(posedge tau2015_clk) begin
    if (rst) begin
      dp_in_valid <= 1'b0;
      dp_in_data  <= '0;
      issue_id    <= '0;
    end else begin
      dp_in_valid <= transfer;
      if (transfer) begin
        dp_in_data <= req_data[grant_id*DATA_W +: DATA_W];
        issue_id   <= grant_id;
      end
    end
  end

  always_ff @(posedge tau2015_clk) begin
    if (rst) begin
      tag_valid <= '0;
      for (int k = 0; k < LAT; k++) tag_id[k] <= '0;
    end else begin
      tag_valid[0] <= dp_in_valid;
      tag_id[0]    <= issue_id;
      for (int k = 1; k < LAT; k++) begin
        tag_valid[k] <= tag_valid[k-1];
        tag_id[k]    <= tag_id[k-1];
      end
    end
  end

  always_ff @(posedge tau2015_clk) begin
    if (rst) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else if (tag_valid[LAT-1]) begin
      rsp_valid <= NUM_REQ'(1) << tag_id[LAT-1];
      rsp_data  <= dp_out_data;
    end else begin
      rsp_valid <= '0;
    end
  end

  always_ff @(posedge tau2015_clk) begin
    if (rst) begin
      inflight <= '0;
    end else begin
      unique case ({transfer, rsp_fire})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

endmodule

// File: tb/tb_chain_slot_arbiter.sv
// Directed bench for chain_slot_arbiter with a LAT-deep inverting datapath model.
module tb_chain_slot_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;
  localparam int LAT     = 4;
  localparam logic [31:0] LANES = 32'hD3C2B1A0;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      dp_in_valid;
  logic [DATA_W-1:0]         dp_in_data;
  logic [DATA_W-1:0]         dp_out_data;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic                      drain_req;
  logic                      halted;

  int errors = 0;
  int checks = 0;
  logic [7:0] lane_val [4];
  logic [7:0] inv_lane [4];
  logic [DATA_W-1:0] dp_pipe [LAT];

  chain_slot_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .LAT(LAT)) dut (
    .tau2015_clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .dp_in_valid(dp_in_valid),
    .dp_in_data(dp_in_data),
    .dp_out_data(dp_out_data),
    .rsp_valid(rsp_valid),
    .rsp_data(rsp_data),
    .drain_req(drain_req),
    .halted(halted)
  );

  always #5 clk = ~clk;

  // Datapath model: registered inverter chain, result LAT cycles after input.
  always @(posedge clk) begin
    dp_pipe[0] <= ~dp_in_data;
    for (int k = 1; k < LAT; k++) dp_pipe[k] <= dp_pipe[k-1];
  end
  assign dp_out_data = dp_pipe[LAT-1];

  task automatic applyStimulus(input logic r, input logic [3:0] v,
                               input logic [31:0] d, input logic dr);
    @(negedge clk);
    rst       = r;
    req_valid = v;
    req_data  = d;
    drain_req = dr;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      $error("[TB] check %s differs", tag);
    end
  endtask

  initial begin
    lane_val[0] = 8'hA0; lane_val[1] = 8'hB1; lane_val[2] = 8'hC2; lane_val[3] = 8'hD3;
    inv_lane[0] = 8'h5F; inv_lane[1] = 8'h4E; inv_lane[2] = 8'h3D; inv_lane[3] = 8'h2C;
    rst = 1'b1; req_valid = '0; req_data = '0; drain_req = 1'b0;

    // Reset: no grant while rst is high, registered outputs cleared
    applyStimulus(1'b1, 4'b1111, LANES, 1'b0);
    checkOutput("rst_ready", 32'(req_ready), 32'h0);
    applyStimulus(1'b1, 4'b1111, LANES, 1'b0);
    applyStimulus(1'b0, 4'b0000, LANES, 1'b0);
    checkOutput("rst_dp_valid", 32'(dp_in_valid), 32'h0);
    checkOutput("rst_dp_data", 32'(dp_in_data), 32'h0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    checkOutput("rst_rsp_data", 32'(rsp_data), 32'h0);
    checkOutput("rst_halted", 32'(halted), 32'h0);

    // Single request: A5 from requester 0 returns 5A six cycles later
    applyStimulus(1'b0, 4'b0001, 32'h000000A5, 1'b0);
    checkOutput("single_ready", 32'(req_ready), 32'h1);
    applyStimulus(1'b0, 4'b0000, 32'h000000A5, 1'b0);
    checkOutput("single_dp_valid", 32'(dp_in_valid), 32'h1);
    checkOutput("single_dp_data", 32'(dp_in_data), 32'hA5);
    for (int c = 2; c <= 5; c++) begin
      applyStimulus(1'b0, 4'b0000, 32'h000000A5, 1'b0);
      checkOutput("single_rsp_early", 32'(rsp_valid), 32'h0);
    end
    applyStimulus(1'b0, 4'b0000, 32'h000000A5, 1'b0);
    checkOutput("single_rsp_valid", 32'(rsp_valid), 32'h1);
    checkOutput("single_rsp_data", 32'(rsp_data), 32'h5A);
    applyStimulus(1'b0, 4'b0000, 32'h000000A5, 1'b0);
    checkOutput("single_rsp_drop", 32'(rsp_valid), 32'h0);
    checkOutput("single_rsp_hold", 32'(rsp_data), 32'h5A);

    // Round-robin: reset pointer, all four requesting for 8 cycles
    applyStimulus(1'b1, 4'b0000, LANES, 1'b0);
    for (int k = 0; k < 14; k++) begin
      applyStimulus(1'b0, (k < 8) ? 4'b1111 : 4'b0000, LANES, 1'b0);
      if (k < 8) checkOutput("rr_ready", 32'(req_ready), 32'(4'b0001 << (k % 4)));
      if (k >= 1 && k <= 8) checkOutput("rr_dp_data", 32'(dp_in_data), 32'(lane_val[(k-1) % 4]));
      if (k >= 6) begin
        checkOutput("rr_rsp_valid", 32'(rsp_valid), 32'(4'b0001 << ((k-6) % 4)));
        checkOutput("rr_rsp_data", 32'(rsp_data), 32'(inv_lane[(k-6) % 4]));
      end else begin
        checkOutput("rr_rsp_idle", 32'(rsp_valid), 32'h0);
      end
    end

    // Fairness: move pointer to 2, then 0 and 1 compete, then 3 joins
    applyStimulus(1'b0, 4'b0010, LANES, 1'b0);
    checkOutput("fair_r1", 32'(req_ready), 32'h2);
    applyStimulus(1'b0, 4'b0011, LANES, 1'b0);
    checkOutput("fair_r0", 32'(req_ready), 32'h1);
    applyStimulus(1'b0, 4'b0011, LANES, 1'b0);
    checkOutput("fair_r1b", 32'(req_ready), 32'h2);
    applyStimulus(1'b0, 4'b1001, LANES, 1'b0);
    checkOutput("fair_r3", 32'(req_ready), 32'h8);
    applyStimulus(1'b0, 4'b1001, LANES, 1'b0);
    checkOutput("fair_r0b", 32'(req_ready), 32'h1);
    for (int c = 0; c < 8; c++) applyStimulus(1'b0, 4'b0000, LANES, 1'b0);

    // Drain: 3 issues (ids 1,2,3), drain from cycle 3, halted at cycle 10
    for (int k = 0; k <= 10; k++) begin
      applyStimulus(1'b0, 4'b1111, LANES, (k >= 3));
      if (k < 3) checkOutput("drain_issue", 32'(req_ready), 32'(4'b0010 << k));
      else checkOutput("drain_no_grant", 32'(req_ready), 32'h0);
      if (k >= 6 && k <= 8) begin
        checkOutput("drain_rsp_valid", 32'(rsp_valid), 32'(4'b0010 << (k-6)));
        checkOutput("drain_rsp_data", 32'(rsp_data), 32'(inv_lane[k-5]));
      end else begin
        checkOutput("drain_rsp_idle", 32'(rsp_valid), 32'h0);
      end
      checkOutput("drain_halted", 32'(halted), (k == 10) ? 32'h1 : 32'h0);
    end
    applyStimulus(1'b0, 4'b0000, LANES, 1'b0);
    checkOutput("drain_halted_hold", 32'(halted), 32'h1);
    applyStimulus(1'b0, 4'b1111, LANES, 1'b0);
    checkOutput("resume_halted", 32'(halted), 32'h0);
    checkOutput("resume_ready", 32'(req_ready), 32'h1);
    for (int c = 0; c < 8; c++) applyStimulus(1'b0, 4'b0000, LANES, 1'b0);

    // Reset mid-flight: 4 in flight (ids 1,2,3,0), then reset discards them
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 4'b1111, LANES, 1'b0);
      checkOutput("mid_issue", 32'(req_ready), 32'(4'b0001 << ((k + 1) % 4)));
    end
    applyStimulus(1'b1, 4'b1111, LANES, 1'b0);
    checkOutput("mid_rst_ready", 32'(req_ready), 32'h0);
    applyStimulus(1'b0, 4'b0000, LANES, 1'b0);
    checkOutput("mid_dp_valid", 32'(dp_in_valid), 32'h0);
    checkOutput("mid_rsp_data", 32'(rsp_data), 32'h0);
    for (int c = 0; c < 7; c++) begin
      applyStimulus(1'b0, 4'b0000, LANES, 1'b0);
      checkOutput("mid_no_rsp", 32'(rsp_valid), 32'h0);
    end
    applyStimulus(1'b0, 4'b1111, LANES, 1'b0);
    checkOutput("mid_ptr_zero", 32'(req_ready), 32'h1);
    for (int c = 1; c <= 6; c++) begin
      applyStimulus(1'b0, 4'b0000, LANES, 1'b0);
      if (c < 6) checkOutput("mid_rsp_wait", 32'(rsp_valid), 32'h0);
    end
    checkOutput("mid_rsp_valid", 32'(rsp_valid), 32'h1);
    checkOutput("mid_rsp_data2", 32'(rsp_data), 32'h5F);

    // Drain cancel: one-cycle drain pulse with 2 in flight, halted never rises
    applyStimulus(1'b0, 4'b1111, LANES, 1'b0);
    checkOutput("cancel_g1", 32'(req_ready), 32'h2);
    applyStimulus(1'b0, 4'b1111, LANES, 1'b0);
    checkOutput("cancel_g2", 32'(req_ready), 32'h4);
    applyStimulus(1'b0, 4'b1111, LANES, 1'b1);
    checkOutput("cancel_no_grant", 32'(req_ready), 32'h0);
    checkOutput("cancel_halted_a", 32'(halted), 32'h0);
    applyStimulus(1'b0, 4'b0000, LANES, 1'b0);
    checkOutput("cancel_halted_b", 32'(halted), 32'h0);
    applyStimulus(1'b0, 4'b1111, LANES, 1'b0);
    checkOutput("cancel_resume", 32'(req_ready), 32'h8);
    for (int k = 5; k <= 10; k++) begin
      applyStimulus(1'b0, 4'b0000, LANES, 1'b0);
      checkOutput("cancel_halted_c", 32'(halted), 32'h0);
      if (k == 6) checkOutput("cancel_rsp1", 32'(rsp_valid), 32'h2);
      if (k == 7) checkOutput("cancel_rsp2", 32'(rsp_valid), 32'h4);
      if (k == 10) begin
        checkOutput("cancel_rsp3", 32'(rsp_valid), 32'h8);
        checkOutput("cancel_rsp3_data", 32'(rsp_data), 32'h2C);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
